// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multi-port register file
package regfile_pkg;

    typedef enum logic {CLEAR, READY} rf_state_t;

    localparam int RF_DW    = 64;
    localparam int RF_NREGS = 32;
    localparam int RF_NRD   = 2;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read port bundle of the multi-port register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DW    = RF_DW,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD
);
    localparam int AW = $clog2(NREGS);

    logic                     we_a;
    logic [AW-1:0]            wa_a;
    logic [DW-1:0]            wd_a;
    logic                     we_b;
    logic [AW-1:0]            wa_b;
    logic [DW-1:0]            wd_b;
    logic [NRD-1:0][AW-1:0]   ra;
    logic [NRD-1:0][DW-1:0]   rd;
    logic                     busy;

    modport master (
        output we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra,
        input  rd, busy
    );

    modport slave (
        input  we_a, wa_a, wd_a, we_b, wa_b, wd_b, ra,
        output rd, busy
    );

endinterface

// File: rtl/regfile_clr_seq.sv
// rtl/regfile_clr_seq.sv - post-reset sweep that zeroes one register per cycle
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    output logic          busy_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          busy_q, busy_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        clr_we_o = 1'b0;
        case (state_q)
            CLEAR: begin
                // the reset edge itself must not touch the array
                clr_we_o = !reset_i;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == AW'(NREGS - 1)) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                    ptr_d   = '0;
                end
            end
            READY: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign busy_o     = busy_q;
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - register file with NRD bypassed read ports, two write ports and optional XZR
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW      = RF_DW,
    parameter int NREGS   = RF_NREGS,
    parameter int NRD     = RF_NRD,
    parameter int ZERO_EN = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic         clk_i,
    input  logic         reset_i,
    regfile_mp_if.slave  bus
);

    logic [DW-1:0] mem_q [NREGS];
    logic          busy;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    regfile_clr_seq #(.NREGS(NREGS)) u_clr_seq (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    function automatic logic is_real_reg(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_EN != 0) && (int'(a) == NREGS - 1));
    endfunction

    // port B is assigned last so it wins an address collision
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (!reset_i && !busy) begin
            if (bus.we_a && is_real_reg(bus.wa_a)) mem_q[bus.wa_a] <= bus.wd_a;
            if (bus.we_b && is_real_reg(bus.wa_b)) mem_q[bus.wa_b] <= bus.wd_b;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [DW-1:0] rd_w;

        always_comb begin
            rd_w = '0;
            if (busy) begin
                rd_w = '0;
            end else if (!is_real_reg(bus.ra[i])) begin
                rd_w = '0;
            end else if (bus.we_b && bus.wa_b == bus.ra[i]) begin
                rd_w = bus.wd_b;
            end else if (bus.we_a && bus.wa_a == bus.ra[i]) begin
                rd_w = bus.wd_a;
            end else begin
                rd_w = mem_q[bus.ra[i]];
            end
        end

        assign bus.rd[i] = rd_w;
    end

    assign bus.busy = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (XZR, no-XZR and 32b/16x4 variants)
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.DW(64), .NREGS(32), .NRD(2)) if0 ();
    regfile_mp_if #(.DW(64), .NREGS(32), .NRD(2)) if1 ();
    regfile_mp_if #(.DW(32), .NREGS(16), .NRD(4)) if2 ();

    assign if1.we_a = if0.we_a;
    assign if1.wa_a = if0.wa_a;
    assign if1.wd_a = if0.wd_a;
    assign if1.we_b = if0.we_b;
    assign if1.wa_b = if0.wa_b;
    assign if1.wd_b = if0.wd_b;
    assign if1.ra   = if0.ra;

    regfile_mp #(.DW(64), .NREGS(32), .NRD(2), .ZERO_EN(1)) dut0 (.clk_i(clk), .reset_i(reset), .bus(if0));
    regfile_mp #(.DW(64), .NREGS(32), .NRD(2), .ZERO_EN(0)) dut1 (.clk_i(clk), .reset_i(reset), .bus(if1));
    regfile_mp #(.DW(32), .NREGS(16), .NRD(4), .ZERO_EN(1)) dut2 (.clk_i(clk), .reset_i(reset), .bus(if2));

    // kind: 0/1/2 = rd of dut0/dut1/dut2, 3 = dut0 busy, 4 = dut2 busy
    typedef struct {
        int          kind;
        int          port;
        logic [63:0] exp;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   nid      = 0;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] actual(input exp_t e);
        case (e.kind)
            0:       return if0.rd[e.port];
            1:       return if1.rd[e.port];
            2:       return {32'h0, if2.rd[e.port]};
            3:       return {63'h0, if0.busy};
            default: return {63'h0, if2.busy};
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [63:0] got;
            e   = sb_q.pop_front();
            got = actual(e);
            checks++;
            if (got !== e.exp) begin
                failures++;
                $display("FAIL chk%0d kind=%0d port=%0d got=%h exp=%h", e.id, e.kind, e.port, got, e.exp);
            end
        end
    end

    task automatic expect_v(input int kind, input int port, input logic [63:0] v);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        e.id   = nid;
        nid++;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_off();
        if0.we_a = 1'b0;
        if0.we_b = 1'b0;
    endtask

    task automatic sweep_check(input int rd_addr);
        if0.ra[0] = 5'(rd_addr);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            if (k == 32) wr_off();
            expect_v(3, 0, (k < 32) ? 64'd1 : 64'd0);
            expect_v(4, 0, (k < 16) ? 64'd1 : 64'd0);
            if (k < 32) expect_v(0, 0, 64'd0);
        end
        cyc();
    endtask

    task automatic readback_zero();
        for (int r = 0; r < 32; r += 2) begin
            if0.ra[0] = 5'(r);
            if0.ra[1] = 5'(r + 1);
            expect_v(0, 0, 64'd0);
            expect_v(0, 1, 64'd0);
            expect_v(1, 0, 64'd0);
            expect_v(1, 1, 64'd0);
            cyc();
        end
    endtask

    logic [31:0] model2 [16];

    function automatic logic [31:0] exp2(input int a);
        if (a == 15) return 32'h0;
        if (if2.we_b && int'(if2.wa_b) == a) return if2.wd_b;
        if (if2.we_a && int'(if2.wa_a) == a) return if2.wd_a;
        return model2[a];
    endfunction

    initial begin
        if0.we_a = 1'b0; if0.wa_a = '0; if0.wd_a = '0;
        if0.we_b = 1'b0; if0.wa_b = '0; if0.wd_b = '0;
        if0.ra   = '0;
        if2.we_a = 1'b0; if2.wa_a = '0; if2.wd_a = '0;
        if2.we_b = 1'b0; if2.wa_b = '0; if2.wd_b = '0;
        if2.ra   = '0;
        for (int i = 0; i < 16; i++) model2[i] = 32'h0;

        // initial clear; writes of 5 to X3 are held through the whole sweep
        cyc();
        reset = 1'b0;
        if0.we_a = 1'b1; if0.wa_a = 5'd3; if0.wd_a = 64'd5;
        expect_v(3, 0, 64'd1);
        expect_v(4, 0, 64'd1);
        sweep_check(3);
        readback_zero();

        // dual write with same-cycle bypass, then stored values
        if0.we_a = 1'b1; if0.wa_a = 5'd1; if0.wd_a = 64'h1111;
        if0.we_b = 1'b1; if0.wa_b = 5'd2; if0.wd_b = 64'h2222;
        if0.ra[0] = 5'd1; if0.ra[1] = 5'd2;
        expect_v(0, 0, 64'h1111);
        expect_v(0, 1, 64'h2222);
        cyc();
        wr_off();
        expect_v(0, 0, 64'h1111);
        expect_v(0, 1, 64'h2222);
        cyc();

        // collision on X7: port B wins
        if0.we_a = 1'b1; if0.wa_a = 5'd7; if0.wd_a = 64'hAAAA;
        if0.we_b = 1'b1; if0.wa_b = 5'd7; if0.wd_b = 64'hBBBB;
        if0.ra[0] = 5'd7; if0.ra[1] = 5'd7;
        expect_v(0, 0, 64'hBBBB);
        expect_v(0, 1, 64'hBBBB);
        cyc();
        wr_off();
        expect_v(0, 0, 64'hBBBB);
        expect_v(1, 1, 64'hBBBB);
        cyc();

        // X31: zero register on dut0, ordinary register on dut1
        for (int c = 0; c < 4; c++) begin
            if0.we_a = 1'b1; if0.wa_a = 5'd31; if0.wd_a = ONES;
            if0.we_b = 1'b1; if0.wa_b = 5'd31; if0.wd_b = ONES;
            if0.ra[0] = 5'd31; if0.ra[1] = 5'd31;
            expect_v(0, 0, 64'd0);
            expect_v(0, 1, 64'd0);
            expect_v(1, 0, ONES);
            cyc();
        end
        wr_off();
        expect_v(0, 0, 64'd0);
        expect_v(1, 1, ONES);
        cyc();

        // fill X0..X30 so the second sweep has something to erase
        for (int r = 0; r < 31; r++) begin
            if0.we_a = 1'b1; if0.wa_a = 5'(r); if0.wd_a = 64'hA5A5_0000_0000_0000 | 64'(r);
            cyc();
        end
        wr_off();
        if0.ra[0] = 5'd10; if0.ra[1] = 5'd30;
        expect_v(0, 0, 64'hA5A5_0000_0000_000A);
        expect_v(0, 1, 64'hA5A5_0000_0000_001E);
        cyc();

        // reset, 10 sweep steps, then reset again mid-clear
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        if0.ra[0] = 5'd20;
        for (int k = 1; k <= 10; k++) begin
            expect_v(3, 0, 64'd1);
            expect_v(4, 0, 64'd1);
            expect_v(0, 0, 64'd0);
            cyc();
        end
        reset = 1'b1;
        expect_v(3, 0, 64'd1);
        cyc();
        reset = 1'b0;
        expect_v(3, 0, 64'd1);
        expect_v(4, 0, 64'd1);
        sweep_check(20);
        readback_zero();

        // 32-bit, 16-entry, 4-read-port variant
        for (int i = 0; i < 8; i++) begin
            if2.we_a = 1'b1; if2.wa_a = 4'(i);      if2.wd_a = 32'hA000_0000 | 32'(i);
            if2.we_b = 1'b1; if2.wa_b = 4'(14 - i); if2.wd_b = 32'hB000_0000 | 32'(14 - i);
            if2.ra[0] = 4'(i);
            if2.ra[1] = 4'(14 - i);
            if2.ra[2] = 4'd15;
            if2.ra[3] = (i == 0) ? 4'd14 : 4'(i - 1);
            for (int p = 0; p < 4; p++) expect_v(2, p, {32'h0, exp2(int'(if2.ra[p]))});
            cyc();
            model2[i]      = if2.wd_a;
            model2[14 - i] = if2.wd_b;
        end
        if2.we_a = 1'b0;
        if2.we_b = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 4; p++) if2.ra[p] = 4'(4 * c + p);
            for (int p = 0; p < 4; p++) expect_v(2, p, {32'h0, (4 * c + p == 15) ? 32'h0 : model2[4 * c + p]});
            cyc();
        end

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
